// File: rtl/icache_refill_pkg.sv
// Line geometry and refill FSM encoding shared by the instruction cache and its refill engine.
package icache_refill_pkg;

    localparam int LINE_WORDS = 128;
    localparam int WORD_BITS  = 32;
    localparam int OFF_BITS   = $clog2(LINE_WORDS);
    localparam int LINE_BITS  = LINE_WORDS * WORD_BITS;
    localparam int BASE_BITS  = 32 - OFF_BITS - 2;

    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } refill_state_e;

endpackage

// File: rtl/refill_linebuf.sv
// Cache-line assembly register: one 32-bit word written per beat, whole line read in parallel.
module refill_linebuf
    import icache_refill_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 wr_en,
    input  logic [OFF_BITS-1:0]  wr_idx,
    input  logic [WORD_BITS-1:0] wr_data,
    output logic [LINE_BITS-1:0] line_data
);

    // NOTE: this store is cleared on reset only because line_data is a visible output with a defined reset value; plain storage arrays normally skip reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            line_data <= '0;
        end else if (wr_en) begin
            line_data[wr_idx*WORD_BITS +: WORD_BITS] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss refill engine: fetches a full line one word per memory handshake, with abort.
module icache_refill
    import icache_refill_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 miss,
    input  logic [31:0]          miss_addr,
    input  logic                 abort,
    output logic [LINE_BITS-1:0] line_data,
    output logic                 line_ready,
    output logic                 busy,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_valid
);

    refill_state_e        state_q, state_d;
    logic [OFF_BITS-1:0]  beat_q, beat_d;
    logic [BASE_BITS-1:0] base_q, base_d;
    logic                 miss_q;
    logic                 miss_rise;
    logic                 beat_wr;

    // Only an edge starts a refill; the level still high after line_ready must not retrigger.
    assign miss_rise = miss & ~miss_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            miss_q  <= miss;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        beat_wr    = 1'b0;
        mem_req    = 1'b0;
        line_ready = 1'b0;
        busy       = (state_q != ST_IDLE);
        mem_addr   = {base_q, beat_q, 2'b00};

        unique case (state_q)
            ST_IDLE: begin
                if (miss_rise && !abort) begin
                    state_d = ST_FETCH;
                    base_d  = miss_addr[31:OFF_BITS+2];
                    beat_d  = '0;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_valid) begin
                    // An aborted beat still completes on the bus, but its data is dropped.
                    if (abort) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_wr = 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            state_d = ST_DONE;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end else if (abort) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                line_ready = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    refill_linebuf u_linebuf (
        .Clk       (Clk),
        .Rst       (Rst),
        .wr_en     (beat_wr),
        .wr_idx    (beat_q),
        .wr_data   (mem_rdata),
        .line_data (line_data)
    );

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: random-latency memory model, line scoreboard, address checker.
`timescale 1ns/1ps
module tb_icache_refill;
    import icache_refill_pkg::*;

    logic                 Clk = 1'b0;
    logic                 Rst = 1'b0;
    logic                 miss = 1'b0;
    logic [31:0]          miss_addr = '0;
    logic                 abort = 1'b0;
    logic [LINE_BITS-1:0] line_data;
    logic                 line_ready;
    logic                 busy;
    logic                 mem_req;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_rdata = '0;
    logic                 mem_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int ready_cnt = 0;

    // Memory model and request tracking
    logic [31:0]          mem_key;
    int                   max_lat = 0;
    bit                   stall_en = 1'b0;
    int                   stall_idx = 0;
    bit                   stalled = 1'b0;
    bit                   pending = 1'b0;
    int                   lat = 0;
    logic [31:0]          p_addr = '0;
    int                   p_idx = 0;
    logic [BASE_BITS-1:0] exp_base = '0;
    int                   exp_issued = 0;
    logic [LINE_BITS-1:0] exp_lines[$];

    icache_refill dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .miss       (miss),
        .miss_addr  (miss_addr),
        .abort      (abort),
        .line_data  (line_data),
        .line_ready (line_ready),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ mem_key;
    endfunction

    // A line is the 128 aligned words of the 512-byte block holding the address, in order.
    function automatic logic [LINE_BITS-1:0] exp_line(input logic [31:0] a);
        logic [LINE_BITS-1:0] l;
        logic [31:0]          blk;
        blk = a & ~32'(LINE_WORDS * 4 - 1);
        for (int i = 0; i < LINE_WORDS; i++) begin
            l[i*WORD_BITS +: WORD_BITS] = mem_word(blk + 32'(4 * i));
        end
        return l;
    endfunction

    // Memory responder: one outstanding read, latency 0..max_lat cycles, optional stall on one word.
    always @(negedge Clk) begin
        if (!Rst) begin
            mem_valid = 1'b0;
            pending   = 1'b0;
            stalled   = 1'b0;
        end else begin
            if (mem_valid) begin
                mem_valid = 1'b0;
                pending   = 1'b0;
            end
            if (pending && mem_req) begin
                check("mem_addr_stable", mem_addr, p_addr);
            end else if (!pending && mem_req) begin
                check("req_within_line", 32'(exp_issued < LINE_WORDS), 32'd1);
                check("mem_addr", mem_addr, {exp_base, OFF_BITS'(exp_issued), 2'b00});
                pending = 1'b1;
                p_addr  = mem_addr;
                p_idx   = exp_issued;
                exp_issued++;
                lat     = int'($urandom_range(max_lat, 0));
            end
            if (pending) begin
                stalled = stall_en && (p_idx == stall_idx);
                if (!stalled) begin
                    if (lat == 0) begin
                        mem_valid = 1'b1;
                        mem_rdata = mem_word(p_addr);
                    end else begin
                        lat--;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every line_ready must match the oldest expected line.
    always @(negedge Clk) begin
        if (Rst && line_ready) begin
            logic [LINE_BITS-1:0] exp;
            ready_cnt++;
            check("line_ready_expected", 32'(exp_lines.size() > 0), 32'd1);
            if (exp_lines.size() > 0) begin
                exp = exp_lines.pop_front();
                n_checks++;
                if (line_data !== exp) begin
                    int bad;
                    bad = 0;
                    for (int i = LINE_WORDS - 1; i >= 0; i--) begin
                        if (line_data[i*WORD_BITS +: WORD_BITS] !== exp[i*WORD_BITS +: WORD_BITS]) bad = i;
                    end
                    n_errors++;
                    $display("FAIL line_data word %0d: got %h expected %h at %0t", bad,
                             line_data[bad*WORD_BITS +: WORD_BITS], exp[bad*WORD_BITS +: WORD_BITS], $time);
                end
            end
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] a, input bit complete);
        tick();
        miss_addr  = a;
        miss       = 1'b1;
        exp_base   = a[31:OFF_BITS+2];
        exp_issued = 0;
        if (complete) exp_lines.push_back(exp_line(a));
    endtask

    task automatic wait_ready(input bit drop_miss, output int cycles);
        cycles = 0;
        while (cycles < 1000) begin
            @(negedge Clk);
            cycles++;
            if (line_ready === 1'b1) break;
        end
        check("ready_in_time", 32'(cycles < 1000), 32'd1);
        #1;
        if (drop_miss) miss = 1'b0;
    endtask

    task automatic wait_stalled();
        int n;
        n = 0;
        while (n < 1000) begin
            tick();
            n++;
            if (stalled) break;
        end
        check("stall_reached", 32'(stalled), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_line_ready"}, 32'(line_ready), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_line_zero"}, 32'(line_data == '0), 32'd1);
    endtask

    initial begin
        int          cyc;
        int          rc;
        logic [31:0] a;

        mem_key = $urandom;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge Clk);
        #1 Rst = 1'b1;

        // 1: single-cycle memory, fixed address, minimum refill time
        max_lat = 0;
        start_miss(32'h0000_0A34, 1'b1);
        wait_ready(1'b1, cyc);
        check("refill_cycles", 32'(cyc), 32'd129);
        tick();
        check("ready_count_t1", 32'(ready_cnt), 32'd1);
        check("idle_after_t1", 32'(busy), 32'd0);

        // 2: same miss, random 0-5 cycle latency
        max_lat = 5;
        start_miss(32'h0000_0A34, 1'b1);
        tick();
        check("busy_in_fetch", 32'(busy), 32'd1);
        wait_ready(1'b1, cyc);
        tick();
        check("ready_count_t2", 32'(ready_cnt), 32'd2);

        // 3: abort at beat 40 with the beat outstanding -> drain then idle
        max_lat   = 2;
        stall_idx = 40;
        stall_en  = 1'b1;
        a         = $urandom;
        rc        = ready_cnt;
        start_miss(a, 1'b0);
        wait_stalled();
        abort = 1'b1;
        tick();
        check("abort_req_drop", 32'(mem_req), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        abort    = 1'b0;
        stall_en = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            tick();
            cyc++;
            check("drain_no_req", 32'(mem_req), 32'd0);
        end
        check("drain_exit", 32'(busy), 32'd0);
        check("drain_absorbed", 32'(pending), 32'd0);
        miss = 1'b0;
        repeat (3) begin
            tick();
            check("no_stray_req", 32'(mem_req), 32'd0);
        end
        check("ready_count_t3", 32'(ready_cnt), 32'(rc));
        start_miss(a, 1'b1);
        wait_ready(1'b1, cyc);

        // 4a: abort coincident with the last beat
        max_lat   = 0;
        stall_idx = LINE_WORDS - 1;
        stall_en  = 1'b1;
        a         = $urandom;
        rc        = ready_cnt;
        start_miss(a, 1'b0);
        wait_stalled();
        stall_en = 1'b0;
        tick();
        check("last_beat_valid", 32'(mem_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_last_idle", 32'(busy), 32'd0);
        check("abort_last_no_ready", 32'(line_ready), 32'd0);
        miss = 1'b0;
        repeat (2) tick();
        check("ready_count_t4a", 32'(ready_cnt), 32'(rc));

        // 4b: abort during the DONE cycle is ignored
        stall_en = 1'b1;
        a        = $urandom;
        start_miss(a, 1'b1);
        wait_stalled();
        stall_en = 1'b0;
        @(negedge Clk);
        @(posedge Clk);
        #1 abort = 1'b1;
        @(negedge Clk);
        #1;
        check("done_abort_ready", 32'(line_ready), 32'd1);
        @(posedge Clk);
        #1 abort = 1'b0;
        miss = 1'b0;
        tick();
        check("done_abort_idle", 32'(busy), 32'd0);
        check("ready_count_t4b", 32'(ready_cnt), 32'(rc + 1));

        // 5: miss level held after line_ready must not restart; new edge at 0x1000 does
        max_lat = 3;
        a       = $urandom;
        start_miss(a, 1'b1);
        wait_ready(1'b0, cyc);
        rc = ready_cnt;
        repeat (3) begin
            tick();
            check("held_miss_idle", 32'(busy), 32'd0);
            check("held_miss_no_req", 32'(mem_req), 32'd0);
        end
        check("ready_count_t5", 32'(ready_cnt), 32'(rc));
        miss = 1'b0;
        start_miss(32'h0000_1000, 1'b1);
        tick();
        check("new_base_addr", mem_addr, 32'h0000_1000);
        wait_ready(1'b1, cyc);

        // 6: asynchronous reset at beat 77
        max_lat   = 1;
        stall_idx = 77;
        stall_en  = 1'b1;
        start_miss($urandom, 1'b0);
        wait_stalled();
        Rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        miss     = 1'b0;
        stall_en = 1'b0;
        repeat (2) tick();
        Rst = 1'b1;
        start_miss($urandom, 1'b1);
        wait_ready(1'b1, cyc);

        // Random addresses and latencies
        for (int k = 0; k < 3; k++) begin
            max_lat = int'($urandom_range(4, 0));
            start_miss($urandom, 1'b1);
            wait_ready(1'b1, cyc);
        end

        repeat (3) tick();
        check("lines_outstanding", 32'(exp_lines.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
